// File: rtl/dma_rd_arbiter.sv
// Round-robin read arbiter in front of a shared DMA read controller.
// Each requester (0 = ifmap, 1 = filter, 2 = bias) asks for a job made of
// several blocks. The winner's job parameters are latched at grant, so the
// requester may change its inputs while the job runs. Jobs with a zero
// block count are rejected without touching the DMA.
module dma_rd_arbiter #(
    parameter int N_REQ     = 3,
    parameter int BIT_TRANS = 18
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [32*N_REQ-1:0]        i_base_addr,
    input  logic [BIT_TRANS*N_REQ-1:0] i_num_trans,
    input  logic [16*N_REQ-1:0]        i_num_blk,
    output logic [N_REQ-1:0]           o_gnt,
    output logic [N_REQ-1:0]           o_done,
    output logic [N_REQ-1:0]           o_err,
    output logic                       o_busy,
    output logic [15:0]                o_blk_cnt,
    output logic                       o_rd_start,
    output logic [31:0]                o_rd_base_addr,
    output logic [BIT_TRANS-1:0]       o_rd_num_trans,
    output logic [15:0]                o_rd_max_blk,
    input  logic                       i_read_done,
    input  logic                       i_ctrl_read_done
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        BUSY,
        DONE
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_rrPtr;
    logic            r_zeroBlk;

    logic            w_found;
    logic [PW-1:0]   w_winIdx;
    logic [PW-1:0]   w_nextPtr;
    int              w_bestOff;
    int              w_off;

    // Pick the active requester closest to the round-robin pointer, counting
    // forward with wrap-around; the smallest forward distance wins.
    always_comb begin
        w_winIdx  = '0;
        w_bestOff = N_REQ;
        w_off     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_off = (k + N_REQ - int'(r_rrPtr)) % N_REQ;
            if (i_req[k] && (w_off < w_bestOff)) begin
                w_bestOff = w_off;
                w_winIdx  = PW'(k);
            end
        end
        w_found   = (w_bestOff < N_REQ);
        w_nextPtr = (int'(w_winIdx) == N_REQ - 1) ? '0 : w_winIdx + 1'b1;
    end

    // Job sequencer: grant, launch the stream, count blocks, report completion.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state        <= IDLE;
            r_rrPtr        <= '0;
            r_zeroBlk      <= 1'b0;
            o_gnt          <= '0;
            o_done         <= '0;
            o_err          <= '0;
            o_busy         <= 1'b0;
            o_blk_cnt      <= '0;
            o_rd_start     <= 1'b0;
            o_rd_base_addr <= '0;
            o_rd_num_trans <= '0;
            o_rd_max_blk   <= '0;
        end else begin
            o_done     <= '0;
            o_err      <= '0;
            o_rd_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        o_gnt          <= '0;
                        o_gnt[w_winIdx] <= 1'b1;
                        o_rd_base_addr <= i_base_addr[int'(w_winIdx)*32 +: 32];
                        o_rd_num_trans <= i_num_trans[int'(w_winIdx)*BIT_TRANS +: BIT_TRANS];
                        o_rd_max_blk   <= i_num_blk[int'(w_winIdx)*16 +: 16];
                        o_blk_cnt      <= '0;
                        o_busy         <= 1'b1;
                        r_zeroBlk      <= 1'b0;
                        r_rrPtr        <= w_nextPtr;
                        r_state        <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (o_rd_max_blk == 16'd0) begin
                        r_zeroBlk <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        o_rd_start <= 1'b1;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (i_read_done && (o_blk_cnt != 16'hFFFF)) begin
                        o_blk_cnt <= o_blk_cnt + 16'd1;
                    end
                    if (i_ctrl_read_done) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    o_done  <= o_gnt;
                    o_err   <= r_zeroBlk ? o_gnt : '0;
                    o_gnt   <= '0;
                    o_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_rd_arbiter.sv
// Randomized self-checking bench for dma_rd_arbiter. A job-level model keeps
// the round-robin pointer and predicts winner, latched parameters, block
// count (saturating), and done/error pulses for each job.
module tb_dma_rd_arbiter;

    logic        clk;
    logic        rstn;
    logic [2:0]  i_req;
    logic [95:0] i_base_addr;
    logic [53:0] i_num_trans;
    logic [47:0] i_num_blk;
    logic [2:0]  o_gnt;
    logic [2:0]  o_done;
    logic [2:0]  o_err;
    logic        o_busy;
    logic [15:0] o_blk_cnt;
    logic        o_rd_start;
    logic [31:0] o_rd_base_addr;
    logic [17:0] o_rd_num_trans;
    logic [15:0] o_rd_max_blk;
    logic        i_read_done;
    logic        i_ctrl_read_done;

    int testsRun;
    int testsFailed;
    int modelPtr;

    dma_rd_arbiter #(.N_REQ(3), .BIT_TRANS(18)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .i_req            (i_req),
        .i_base_addr      (i_base_addr),
        .i_num_trans      (i_num_trans),
        .i_num_blk        (i_num_blk),
        .o_gnt            (o_gnt),
        .o_done           (o_done),
        .o_err            (o_err),
        .o_busy           (o_busy),
        .o_blk_cnt        (o_blk_cnt),
        .o_rd_start       (o_rd_start),
        .o_rd_base_addr   (o_rd_base_addr),
        .o_rd_num_trans   (o_rd_num_trans),
        .o_rd_max_blk     (o_rd_max_blk),
        .i_read_done      (i_read_done),
        .i_ctrl_read_done (i_ctrl_read_done)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts and reports
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Model: first requester found walking forward from the pointer
    function automatic int modelPick(input logic [2:0] mask);
        for (int off = 0; off < 3; off++) begin
            if (mask[(modelPtr + off) % 3]) return (modelPtr + off) % 3;
        end
        return -1;
    endfunction

    // Run one complete job from IDLE and check it against the model
    task automatic applyStimulus(input logic [2:0] mask, input logic [15:0] nb,
                                 input logic [31:0] base, input logic [17:0] nt,
                                 input int pulses, input bit simul, input bit chg,
                                 input int gapMax);
        int          win;
        int          expCnt;
        logic [2:0]  expG;
        win  = modelPick(mask);
        expG = 3'b001 << win;
        i_req       = mask;
        i_base_addr = {$urandom, $urandom, $urandom};
        i_num_trans = {22'($urandom), $urandom};
        i_num_blk   = {16'($urandom), $urandom};
        i_base_addr[win*32 +: 32] = base;
        i_num_trans[win*18 +: 18] = nt;
        i_num_blk[win*16 +: 16]   = nb;
        tick();
        checkOutput("gnt", 64'(o_gnt), 64'(expG));
        checkOutput("busyGrant", 64'(o_busy), 64'd1);
        checkOutput("startAtGrant", 64'(o_rd_start), 64'd0);
        checkOutput("doneAtGrant", 64'(o_done), 64'd0);
        checkOutput("blkCntCleared", 64'(o_blk_cnt), 64'd0);
        checkOutput("baseAddr", 64'(o_rd_base_addr), 64'(base));
        checkOutput("numTrans", 64'(o_rd_num_trans), 64'(nt));
        checkOutput("maxBlk", 64'(o_rd_max_blk), 64'(nb));
        modelPtr = (win + 1) % 3;
        i_read_done = 1'b1;
        tick();
        i_read_done = 1'b0;
        checkOutput("rdStart", 64'(o_rd_start), 64'(nb != 16'd0));
        if (chg) begin
            i_base_addr = {$urandom, $urandom, $urandom};
            i_num_trans = {22'($urandom), $urandom};
            i_num_blk   = {16'($urandom), $urandom};
        end
        if (nb != 16'd0) begin
            for (int p = 0; p < pulses; p++) begin
                i_read_done = 1'b1;
                if (simul && p == pulses - 1) i_ctrl_read_done = 1'b1;
                tick();
                i_read_done      = 1'b0;
                i_ctrl_read_done = 1'b0;
                if (p == 0) checkOutput("startOneCycle", 64'(o_rd_start), 64'd0);
                if (!(simul && p == pulses - 1)) begin
                    repeat ($urandom_range(0, gapMax)) tick();
                end
            end
            if (!simul || pulses == 0) begin
                i_ctrl_read_done = 1'b1;
                tick();
                i_ctrl_read_done = 1'b0;
            end
            expCnt = (pulses > 65535) ? 65535 : pulses;
            checkOutput("blkCnt", 64'(o_blk_cnt), 64'(expCnt));
            checkOutput("doneEarly", 64'(o_done), 64'd0);
            checkOutput("gntHeld", 64'(o_gnt), 64'(expG));
            checkOutput("baseHeld", 64'(o_rd_base_addr), 64'(base));
            i_read_done = 1'b1;
            tick();
            i_read_done = 1'b0;
            checkOutput("done", 64'(o_done), 64'(expG));
            checkOutput("errClear", 64'(o_err), 64'd0);
            checkOutput("gntCleared", 64'(o_gnt), 64'd0);
            checkOutput("busyCleared", 64'(o_busy), 64'd0);
            checkOutput("blkCntHold", 64'(o_blk_cnt), 64'(expCnt));
        end else begin
            tick();
            checkOutput("zeroDone", 64'(o_done), 64'(expG));
            checkOutput("zeroErr", 64'(o_err), 64'(expG));
            checkOutput("zeroGntCleared", 64'(o_gnt), 64'd0);
            checkOutput("zeroBlkCnt", 64'(o_blk_cnt), 64'd0);
        end
        i_req = 3'b000;
    endtask

    // Reset, directed scenarios, then randomized jobs
    initial begin
        logic [2:0]  mask;
        logic [15:0] nb;
        int          pulses;
        testsRun         = 0;
        testsFailed      = 0;
        modelPtr         = 0;
        rstn             = 1'b0;
        i_req            = '0;
        i_base_addr      = '0;
        i_num_trans      = '0;
        i_num_blk        = '0;
        i_read_done      = 1'b0;
        i_ctrl_read_done = 1'b0;
        tick();
        tick();
        checkOutput("rstGnt", 64'(o_gnt), 64'd0);
        checkOutput("rstBusy", 64'(o_busy), 64'd0);
        checkOutput("rstBlkCnt", 64'(o_blk_cnt), 64'd0);
        checkOutput("rstStart", 64'(o_rd_start), 64'd0);
        checkOutput("rstBase", 64'(o_rd_base_addr), 64'd0);
        checkOutput("rstMaxBlk", 64'(o_rd_max_blk), 64'd0);
        rstn = 1'b1;

        for (int j = 0; j < 4; j++) begin
            applyStimulus(3'b111, 16'd1, $urandom, 18'($urandom), 1, 1'b0, 1'b0, 1);
        end
        applyStimulus(3'b001, 16'd4, 32'h1000_0000, 18'd16, 4, 1'b0, 1'b0, 2);
        applyStimulus(3'b010, 16'd0, $urandom, 18'($urandom), 0, 1'b0, 1'b0, 0);
        applyStimulus(3'b100, 16'd2, $urandom, 18'($urandom), 2, 1'b1, 1'b0, 1);
        applyStimulus(3'b001, 16'd3, $urandom, 18'($urandom), 3, 1'b0, 1'b1, 1);
        applyStimulus(3'b010, 16'd5, $urandom, 18'($urandom), 65537, 1'b0, 1'b0, 0);

        i_req       = 3'b001;
        i_num_blk   = {16'd0, 16'd0, 16'd3};
        i_base_addr = {32'd0, 32'd0, 32'hABCD_0000};
        tick();
        tick();
        i_read_done = 1'b1;
        tick();
        i_read_done = 1'b0;
        rstn = 1'b0;
        tick();
        rstn  = 1'b1;
        i_req = 3'b000;
        modelPtr = 0;
        checkOutput("midRstGnt", 64'(o_gnt), 64'd0);
        checkOutput("midRstDone", 64'(o_done), 64'd0);
        checkOutput("midRstBusy", 64'(o_busy), 64'd0);
        checkOutput("midRstBlkCnt", 64'(o_blk_cnt), 64'd0);
        checkOutput("midRstBase", 64'(o_rd_base_addr), 64'd0);
        tick();
        checkOutput("midRstNoDone", 64'(o_done), 64'd0);
        applyStimulus(3'b100, 16'd1, $urandom, 18'($urandom), 1, 1'b0, 1'b0, 1);

        for (int j = 0; j < 30; j++) begin
            mask   = 3'($urandom_range(1, 7));
            nb     = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
            pulses = int'($urandom_range(0, 6));
            applyStimulus(mask, nb, $urandom, 18'($urandom), pulses,
                          (pulses > 0) && ($urandom_range(0, 1) == 1),
                          $urandom_range(0, 1) == 1, 2);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
